// File: rtl/encoder_w_p_if.sv
// Request/result bundle for the encoder_w_p registered priority encoder.
// Define ENCODER_MULTI_HOT_FLAG_EN to add the registered 'multi' flag.
interface encoder_w_p_if #(
  parameter int WIDTH = 4
);
  localparam int OUT_W = $clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] a;
  logic [OUT_W-1:0] y;
  logic             valid;
`ifdef ENCODER_MULTI_HOT_FLAG_EN
  logic             multi;
`endif

`ifdef ENCODER_MULTI_HOT_FLAG_EN
  modport master (output en, output a, input y, input valid, input multi);
  modport slave  (input en, input a, output y, output valid, output multi);
`else
  modport master (output en, output a, input y, input valid);
  modport slave  (input en, input a, output y, output valid);
`endif
endinterface

// File: rtl/encoder_w_p.sv
// Registered WIDTH-to-log2(WIDTH) priority encoder with enable; MSB wins.
// Optional macro ENCODER_MULTI_HOT_FLAG_EN adds a registered multi-hot flag.
module encoder_w_p #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  encoder_w_p_if.slave  bus
);
  localparam int OUT_W = $clog2(WIDTH);

  logic [OUT_W-1:0] y_q, y_d;
  logic             valid_q, valid_d;
`ifdef ENCODER_MULTI_HOT_FLAG_EN
  logic             multi_q, multi_d;
`endif

  // Ascending scan: a later (higher) set bit overwrites, so the MSB wins.
  always_comb begin
    y_d     = '0;
    valid_d = 1'b0;
    if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.a[i]) begin
          y_d     = i[OUT_W-1:0];
          valid_d = 1'b1;
        end
      end
    end
  end

`ifdef ENCODER_MULTI_HOT_FLAG_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    multi_d = bus.en && ((bus.a & (bus.a - WIDTH'(1))) != '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
`ifdef ENCODER_MULTI_HOT_FLAG_EN
      multi_q <= 1'b0;
`endif
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
`ifdef ENCODER_MULTI_HOT_FLAG_EN
      multi_q <= multi_d;
`endif
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
`ifdef ENCODER_MULTI_HOT_FLAG_EN
  assign bus.multi = multi_q;
`endif
endmodule

// File: tb/tb_encoder_w_p.sv
// Self-checking bench for encoder_w_p: directed plan, exhaustive sweep with a
// mid-sequence reset, then random traffic against an arithmetic reference model.
module tb_encoder_w_p;
  localparam int WIDTH = 4;
  localparam int OUT_W = $clog2(WIDTH);

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;

  // Inputs sampled at the most recent rising edge, used by the reference model.
  bit               lastRst;
  bit               lastEn;
  logic [WIDTH-1:0] lastA;

  encoder_w_p_if #(.WIDTH(WIDTH)) bus ();

  encoder_w_p #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Highest set bit of a nonzero value v is clog2(v+1)-1.
  function automatic logic [OUT_W-1:0] refY(bit r, bit e, logic [WIDTH-1:0] v);
    if (!r || !e || v == '0) return '0;
    return OUT_W'($clog2(int'(v) + 1) - 1);
  endfunction

  function automatic logic refValid(bit r, bit e, logic [WIDTH-1:0] v);
    return r && e && (v != '0);
  endfunction

  function automatic logic refMulti(bit r, bit e, logic [WIDTH-1:0] v);
    return r && e && ($countones(v) > 1);
  endfunction

  task automatic checkOutput(input string tag);
    logic [OUT_W-1:0] expY;
    logic             expValid;
    expY     = refY(lastRst, lastEn, lastA);
    expValid = refValid(lastRst, lastEn, lastA);
    testCount++;
    assert (bus.y === expY) else begin
      failCount++;
      $error("[TB] FAIL %s y: actual=%0d required=%0d (rst_n=%0b en=%0b a=%b)",
             tag, bus.y, expY, lastRst, lastEn, lastA);
    end
    testCount++;
    assert (bus.valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s valid: actual=%b required=%b (rst_n=%0b en=%0b a=%b)",
             tag, bus.valid, expValid, lastRst, lastEn, lastA);
    end
`ifdef ENCODER_MULTI_HOT_FLAG_EN
    testCount++;
    assert (bus.multi === refMulti(lastRst, lastEn, lastA)) else begin
      failCount++;
      $error("[TB] FAIL %s multi: actual=%b required=%b (rst_n=%0b en=%0b a=%b)",
             tag, bus.multi, refMulti(lastRst, lastEn, lastA), lastRst, lastEn, lastA);
    end
`endif
  endtask

  // Drive inputs away from the edge, clock once, then check just after the edge.
  task automatic applyStimulus(input bit r, input bit e, input logic [WIDTH-1:0] v,
                               input string tag);
    @(negedge clk);
    rst_n  = r;
    bus.en = e;
    bus.a  = v;
    @(posedge clk);
    lastRst = r;
    lastEn  = e;
    lastA   = v;
    #1;
    checkOutput(tag);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.a     = '0;

    applyStimulus(1'b0, 1'b1, 4'b1000, "reset0");
    applyStimulus(1'b0, 1'b1, 4'b1000, "reset1");
    applyStimulus(1'b1, 1'b1, 4'b1000, "resetRelease");

    applyStimulus(1'b1, 1'b0, 4'b0001, "disable");
    applyStimulus(1'b1, 1'b1, 4'b0001, "enableBit0");

    applyStimulus(1'b1, 1'b1, 4'b0001, "sweep0");
    applyStimulus(1'b1, 1'b1, 4'b0010, "sweep1");
    applyStimulus(1'b1, 1'b1, 4'b0100, "sweep2");
    applyStimulus(1'b1, 1'b1, 4'b1000, "sweep3");

    applyStimulus(1'b1, 1'b1, 4'b0111, "prio0111");
    applyStimulus(1'b1, 1'b1, 4'b1010, "prio1010");
    applyStimulus(1'b1, 1'b1, 4'b0000, "zeroInput");

    for (int e = 0; e < 2; e++) begin
      for (int v = 0; v < 16; v++) begin
        if (e == 1 && v == 8) applyStimulus(1'b0, 1'b1, 4'b1111, "exhaustReset");
        applyStimulus(1'b1, e[0], v[WIDTH-1:0], $sformatf("exhaust_en%0d_a%0d", e, v));
      end
    end

    for (int n = 0; n < 200; n++) begin
      applyStimulus(($urandom_range(0, 15) != 0), $urandom_range(0, 3) != 0,
                    WIDTH'($urandom), $sformatf("random%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
